// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end owning the pc, with stall hold,
// redirect squash and out-of-range halt.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_LIMIT = 32'd127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_taken,
   input  logic        jump,
   input  logic [31:0] br_base,
   input  logic [15:0] br_offset,
   input  logic [25:0] jump_target,
   output logic [31:0] pc,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        fetch_err,
   output logic [31:0] fetch_count
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t state;
   logic [31:0] fetch_pc, target;
   logic redirect, accept;
   assign redirect = jump | br_taken;
   assign target = jump ? {br_base[31:26], jump_target} : br_base + {{16{br_offset[15]}}, br_offset};
   // Re-presenting inst_pc on stall makes the memory re-latch the held word.
   assign pc = (stall && !redirect) ? inst_pc : fetch_pc;
   assign accept = inst_valid && !stall && !redirect;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         inst_pc     <= 32'd0;
         inst_valid  <= 1'b0;
         fetch_err   <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         if (accept) fetch_count <= fetch_count + 32'd1;
         case (state)
            BOOT: begin
               fetch_pc   <= RESET_PC + 32'd1;
               inst_pc    <= RESET_PC;
               inst_valid <= 1'b1;
               state      <= RUN;
            end
            RUN:
               if (redirect) begin
                  inst_valid <= 1'b0;
                  if (target <= PC_LIMIT) fetch_pc <= target;
                  else begin
                     state     <= HALT;
                     fetch_err <= 1'b1;
                  end
               end else if (!stall) begin
                  if (fetch_pc > PC_LIMIT) begin
                     state      <= HALT;
                     fetch_err  <= 1'b1;
                     inst_valid <= 1'b0;
                  end else begin
                     inst_pc    <= fetch_pc;
                     inst_valid <= 1'b1;
                     fetch_pc   <= fetch_pc + 32'd1;
                  end
               end
            default: inst_valid <= 1'b0;
         endcase
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus randomized stimulus against a behavioural
// fetch model and an instruction-memory coherence check.
module tb_fetch_unit;
   logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, br_taken = 1'b0, jump = 1'b0;
   logic [31:0] br_base = 32'd0;
   logic [15:0] br_offset = 16'd0;
   logic [25:0] jump_target = 26'd0;
   logic [31:0] pc, inst_pc, fetch_count;
   logic        inst_valid, fetch_err;
   int checks = 0, failures = 0;
   fetch_unit #(.RESET_PC(32'd0), .PC_LIMIT(32'd127)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .jump(jump),
      .br_base(br_base), .br_offset(br_offset), .jump_target(jump_target),
      .pc(pc), .inst_pc(inst_pc), .inst_valid(inst_valid), .fetch_err(fetch_err),
      .fetch_count(fetch_count)
   );
   always #5 clk = ~clk;
   // instruction memory: no reset, latches memdata[pc] every edge
   logic [31:0] memdata [256];
   logic [31:0] mem_q;
   always @(posedge clk) mem_q <= memdata[pc[7:0]];
   // behavioural model: phase 0 boot, 1 running, 2 halted
   int unsigned m_phase;
   logic [31:0] m_fpc, m_ipc, m_cnt;
   logic        m_val, m_err;
   task automatic cmp(string n, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
      end
   endtask
   function automatic logic [31:0] exp_pc();
      return (stall && !(jump || br_taken)) ? m_ipc : m_fpc;
   endfunction
   task automatic check_all();
      cmp("pc", pc, exp_pc());
      cmp("inst_pc", inst_pc, m_ipc);
      cmp("inst_valid", 32'(inst_valid), 32'(m_val));
      cmp("fetch_err", 32'(fetch_err), 32'(m_err));
      cmp("fetch_count", fetch_count, m_cnt);
      if (inst_valid) cmp("mem_coherent", mem_q, memdata[inst_pc[7:0]]);
   endtask
   task automatic model_edge();
      logic [31:0] tgt;
      logic redir;
      redir = jump || br_taken;
      tgt = jump ? {br_base[31:26], jump_target} : br_base + 32'($signed(br_offset));
      if (m_val && !stall && !redir) m_cnt = m_cnt + 32'd1;
      if (m_phase == 0) begin
         m_ipc = 32'd0; m_fpc = 32'd1; m_val = 1'b1; m_phase = 1;
      end else if (m_phase == 1) begin
         if (redir && tgt <= 32'd127) begin
            m_fpc = tgt; m_val = 1'b0;
         end else if (redir || (!stall && m_fpc > 32'd127)) begin
            m_phase = 2; m_err = 1'b1; m_val = 1'b0;
         end else if (!stall) begin
            m_ipc = m_fpc; m_fpc = m_fpc + 32'd1; m_val = 1'b1;
         end
      end
   endtask
   // called at a negedge; returns at the next negedge
   task automatic step(logic s, logic b, logic j, logic [31:0] base, logic [15:0] off, logic [25:0] jt);
      check_all();
      stall = s; br_taken = b; jump = j; br_base = base; br_offset = off; jump_target = jt;
      #1 cmp("pc_mux", pc, exp_pc());
      model_edge();
      @(negedge clk);
   endtask
   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0);
   endtask
   // asserts reset mid-cycle and checks the clear without any clock edge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 m_phase = 0; m_fpc = 32'd0; m_ipc = 32'd0; m_val = 1'b0; m_err = 1'b0; m_cnt = 32'd0;
      check_all();
      {stall, br_taken, jump} = 3'b000; br_base = 32'd0; br_offset = 16'd0; jump_target = 26'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic rand_step();
      int r;
      logic [31:0] base;
      logic [25:0] jt;
      r = int'($urandom_range(0, 99));
      base = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 130);
      jt = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(0, 135));
      step($urandom_range(0, 9) < 3, r >= 4 && r < 12, r < 6, base,
           16'(int'($urandom_range(0, 40)) - 20), jt);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) memdata[i] = $urandom;
      @(negedge clk);
      do_reset();
      cmp("rst_pc", pc, 32'd0);
      cmp("rst_valid", 32'(inst_valid), 32'd0);
      cmp("rst_count", fetch_count, 32'd0);
      idle(1);
      cmp("boot_ipc", inst_pc, 32'd0);
      cmp("boot_valid", 32'(inst_valid), 32'd1);
      cmp("boot_pc", pc, 32'd1);
      idle(3);
      cmp("seq_count", fetch_count, 32'd3);
      cmp("seq_ipc", inst_pc, 32'd3);
      cmp("seq_pc", pc, 32'd4);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0);
      cmp("stall_pc", pc, 32'd4);
      cmp("stall_ipc", inst_pc, 32'd4);
      step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0);
      cmp("stall_valid", 32'(inst_valid), 32'd1);
      cmp("stall_count", fetch_count, 32'd4);
      idle(1);
      cmp("resume_ipc", inst_pc, 32'd5);
      cmp("resume_count", fetch_count, 32'd5);
      step(1'b0, 1'b1, 1'b0, 32'd5, 16'hFFFE, 26'd0);
      cmp("br_squash", 32'(inst_valid), 32'd0);
      cmp("br_pc", pc, 32'd3);
      idle(1);
      cmp("br_ipc", inst_pc, 32'd3);
      cmp("br_valid", 32'(inst_valid), 32'd1);
      cmp("br_count", fetch_count, 32'd5);
      step(1'b0, 1'b1, 1'b1, 32'd8, 16'd0, 26'd20);
      idle(1);
      cmp("jump_wins_ipc", inst_pc, 32'd20);
      cmp("jump_wins_valid", 32'(inst_valid), 32'd1);
      step(1'b0, 1'b1, 1'b0, 32'd120, 16'd10, 26'd0);
      cmp("halt_err", 32'(fetch_err), 32'd1);
      cmp("halt_valid", 32'(inst_valid), 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'd0, 16'd0, 26'd5);
      cmp("halt_ignore_ipc", inst_pc, 32'd20);
      cmp("halt_ignore_valid", 32'(inst_valid), 32'd0);
      do_reset();
      cmp("rst2_err", 32'(fetch_err), 32'd0);
      cmp("rst2_pc", pc, 32'd0);
      idle(128);
      cmp("last_ipc", inst_pc, 32'd127);
      cmp("last_valid", 32'(inst_valid), 32'd1);
      cmp("last_count", fetch_count, 32'd127);
      idle(1);
      cmp("end_err", 32'(fetch_err), 32'd1);
      cmp("end_valid", 32'(inst_valid), 32'd0);
      cmp("end_count", fetch_count, 32'd128);
      step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0);
      do_reset();
      for (int e = 0; e < 12; e++) begin
         for (int i = 0; i < 150; i++) rand_step();
         do_reset();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
